// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector execution unit.
package vec_pkg;

  localparam int unsigned LANES_D = 6;
  localparam int unsigned LW_D    = 32;

  // Lane operation codes
  typedef enum logic [2:0] {
    VOP_ADD    = 3'b000,
    VOP_SUB    = 3'b001,
    VOP_MUL    = 3'b010,
    VOP_SATADD = 3'b011,
    VOP_SLL    = 3'b100,
    VOP_SRL    = 3'b101,
    VOP_AND    = 3'b110,
    VOP_PASSB  = 3'b111
  } vop_t;

  // Extract lane idx from a default-sized packed vector
  function automatic logic [LW_D-1:0] lane_get(input logic [LANES_D*LW_D-1:0] vector,
                                               input int unsigned idx);
    return vector[idx*LW_D +: LW_D];
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU; all arithmetic unsigned, modulo 2^LW.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned LW  = LW_D,
  parameter int unsigned SHW = $clog2(LW)
) (
  input  vop_t          op,
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW-1:0] y
);

  logic [LW:0]    sum_c;
  logic [SHW-1:0] shamt_c;

  // Operation decode; the carry-out of sum_c drives saturation
  always_comb begin
    sum_c   = {1'b0, a} + {1'b0, b};
    shamt_c = b[SHW-1:0];
    y       = '0;
    case (op)
      VOP_ADD:    y = sum_c[LW-1:0];
      VOP_SUB:    y = a - b;
      VOP_MUL:    y = a * b;
      VOP_SATADD: y = sum_c[LW] ? {LW{1'b1}} : sum_c[LW-1:0];
      VOP_SLL:    y = a << shamt_c;
      VOP_SRL:    y = a >> shamt_c;
      VOP_AND:    y = a & b;
      VOP_PASSB:  y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_pipe.sv
// Two-stage pipelined vector EX unit with valid/ready handshake and flush.
module vec_exec_pipe
  import vec_pkg::*;
#(
  parameter int unsigned LANES = LANES_D,
  parameter int unsigned LW    = LW_D,
  parameter int unsigned SHW   = $clog2(LW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  vop_t                op,
  input  logic                vec,
  input  logic                bcast_b,
  input  logic [LANES*LW-1:0] a,
  input  logic [LANES*LW-1:0] b,
  input  logic [LW-1:0]       scalar_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*LW-1:0] result,
  output logic                zero
);

  localparam int unsigned VW = LANES * LW;

  logic          s1_valid;
  vop_t          s1_op;
  logic          s1_vec;
  logic [VW-1:0] s1_a;
  logic [VW-1:0] s1_b;
  logic          s2_valid;

  logic          s1_en_c;
  logic          s2_en_c;
  logic [VW-1:0] b_sel_c;
  logic [VW-1:0] lane_y_c;
  logic [VW-1:0] res_c;
  logic          zero_c;

  // Stage enables: a stage may load when empty or when its contents move on
  always_comb begin
    s2_en_c  = !s2_valid || out_ready;
    s1_en_c  = !s1_valid || s2_en_c;
    in_ready = s1_en_c && !flush;
  end

  // Per-lane operand select, ALU and scalar-mode masking
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign b_sel_c[g*LW +: LW] = bcast_b ? scalar_b : b[g*LW +: LW];

    vec_lane_alu #(
      .LW  (LW),
      .SHW (SHW)
    ) u_alu (
      .op (s1_op),
      .a  (s1_a[g*LW +: LW]),
      .b  (s1_b[g*LW +: LW]),
      .y  (lane_y_c[g*LW +: LW])
    );

    if (g == 0) begin : g_l0
      assign res_c[g*LW +: LW] = lane_y_c[g*LW +: LW];
    end else begin : g_ln
      assign res_c[g*LW +: LW] = s1_vec ? lane_y_c[g*LW +: LW] : '0;
    end
  end

  // Inactive lanes are already zero, so a full-width compare covers both modes
  assign zero_c = (res_c == '0);

  // S1: latch selected operands, op and mode
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= VOP_ADD;
      s1_vec   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_en_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op;
        s1_vec <= vec;
        s1_a   <= a;
        s1_b   <= b_sel_c;
      end
    end
  end

  // S2: latch lane results and zero flag; held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_en_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_c;
        zero   <= zero_c;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_vec_exec_pipe.sv
// Scoreboard bench for vec_exec_pipe with directed vectors.
module tb_vec_exec_pipe;
  import vec_pkg::*;

  localparam int unsigned LANES = 6;
  localparam int unsigned LW    = 32;
  localparam int unsigned VW    = LANES * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vop_t          op;
  logic          vec;
  logic          bcast_b;
  logic [VW-1:0] a;
  logic [VW-1:0] b;
  logic [LW-1:0] scalar_b;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] result;
  logic          zero;

  typedef struct packed {
    logic [VW-1:0] res;
    logic          z;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  vec_exec_pipe #(.LANES(LANES), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .vec       (vec),
    .bcast_b   (bcast_b),
    .a         (a),
    .b         (b),
    .scalar_b  (scalar_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3,
                                       input logic [31:0] l4, input logic [31:0] l5);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] splat(input logic [31:0] v);
    return {6{v}};
  endfunction

  task automatic check1(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: pop and compare on every consumed output
  always @(negedge clk) begin
    if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, want no output", result);
      end else begin
        mon_e = exp_q.pop_front();
        check1("result", result, mon_e.res);
        check1("zero", VW'(zero), VW'(mon_e.z));
      end
    end
  end

  // Present one op, wait for acceptance, record its expected response
  task automatic issue(input vop_t o, input logic v, input logic bc,
                       input logic [VW-1:0] xa, input logic [VW-1:0] xb,
                       input logic [LW-1:0] sb, input logic [VW-1:0] er, input logic ez);
    int n = 0;
    bit done = 1'b0;
    exp_t e;
    op = o; vec = v; bcast_b = bc; a = xa; b = xb; scalar_b = sb;
    in_valid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.res = er;
        e.z   = ez;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, want 1", in_ready);
    end
  endtask

  // Wait until every expected response has been observed
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = VOP_ADD; vec = 1'b0; bcast_b = 1'b0; a = '0; b = '0; scalar_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_out_valid", VW'(out_valid), VW'(1'b0));
    check1("rst_result", result, '0);
    check1("rst_zero", VW'(zero), VW'(1'b0));
    rst = 1'b0;
    #1;
    check1("rst_in_ready", VW'(in_ready), VW'(1'b1));
    @(posedge clk); #1;

    // ADD with latency check
    issue(VOP_ADD, 1'b1, 1'b0, mk(1, 2, 3, 4, 5, 6), mk(10, 20, 30, 40, 50, 60), 32'd0,
          mk(11, 22, 33, 44, 55, 66), 1'b0);
    check1("lat_cycle1_valid", VW'(out_valid), VW'(1'b0));
    @(posedge clk); #1;
    check1("lat_cycle2_valid", VW'(out_valid), VW'(1'b1));
    drain();

    // SATADD clamps on carry, ADD wraps
    issue(VOP_SATADD, 1'b1, 1'b0, mk(32'hFFFF_FFF0, 5, 0, 0, 0, 0), mk(32'h20, 6, 0, 0, 0, 0), 32'd0,
          mk(32'hFFFF_FFFF, 11, 0, 0, 0, 0), 1'b0);
    issue(VOP_ADD, 1'b1, 1'b0, mk(32'hFFFF_FFF0, 5, 0, 0, 0, 0), mk(32'h20, 6, 0, 0, 0, 0), 32'd0,
          mk(32'h10, 11, 0, 0, 0, 0), 1'b0);
    drain();

    // MUL with broadcast, vector and scalar
    issue(VOP_MUL, 1'b1, 1'b1, mk(1, 2, 3, 4, 5, 6), splat(32'hDEAD_BEEF), 32'd3,
          mk(3, 6, 9, 12, 15, 18), 1'b0);
    issue(VOP_MUL, 1'b0, 1'b1, mk(1, 2, 3, 4, 5, 6), splat(32'hDEAD_BEEF), 32'd3,
          mk(3, 0, 0, 0, 0, 0), 1'b0);
    issue(VOP_MUL, 1'b1, 1'b0, splat(32'h0001_0000), splat(32'h0001_0001), 32'd0,
          splat(32'h0001_0000), 1'b0);
    drain();

    // Zero flag, scalar-mode zero, shifts and logic ops
    issue(VOP_SUB, 1'b1, 1'b0, splat(7), splat(7), 32'd0, splat(0), 1'b1);
    issue(VOP_SUB, 1'b0, 1'b0, mk(7, 7, 7, 8, 7, 7), splat(7), 32'd0, splat(0), 1'b1);
    issue(VOP_SUB, 1'b1, 1'b0, mk(0, 5, 0, 0, 0, 0), mk(1, 2, 0, 0, 0, 0), 32'd0,
          mk(32'hFFFF_FFFF, 3, 0, 0, 0, 0), 1'b0);
    issue(VOP_SLL, 1'b1, 1'b1, splat(1), splat(0), 32'd33, splat(2), 1'b0);
    issue(VOP_SRL, 1'b1, 1'b0, splat(32'h8000_0000), splat(31), 32'd0, splat(1), 1'b0);
    issue(VOP_AND, 1'b1, 1'b0, splat(32'hF0F0), splat(32'hFF00), 32'd0, splat(32'hF000), 1'b0);
    issue(VOP_PASSB, 1'b1, 1'b0, splat(32'h1234), mk(9, 8, 7, 6, 5, 4), 32'd0,
          mk(9, 8, 7, 6, 5, 4), 1'b0);
    drain();

    // Backpressure: two held, third waits on input, order preserved
    out_ready = 1'b0;
    issue(VOP_ADD, 1'b1, 1'b0, splat(1), splat(1), 32'd0, splat(2), 1'b0);
    issue(VOP_ADD, 1'b1, 1'b0, splat(2), splat(1), 32'd0, splat(3), 1'b0);
    fork
      issue(VOP_ADD, 1'b1, 1'b0, splat(3), splat(1), 32'd0, splat(4), 1'b0);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check1("stall_in_ready", VW'(in_ready), VW'(1'b0));
          check1("stall_out_valid", VW'(out_valid), VW'(1'b1));
          check1("stall_result_held", result, splat(2));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two in flight; op presented during flush is dropped
    out_ready = 1'b0;
    issue(VOP_ADD, 1'b1, 1'b0, splat(5), splat(5), 32'd0, splat(10), 1'b0);
    issue(VOP_ADD, 1'b1, 1'b0, splat(6), splat(5), 32'd0, splat(11), 1'b0);
    flush = 1'b1;
    op = VOP_PASSB; vec = 1'b1; bcast_b = 1'b0; b = splat(99); in_valid = 1'b1;
    @(negedge clk);
    check1("flush_in_ready", VW'(in_ready), VW'(1'b0));
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check1("flush_out_valid", VW'(out_valid), VW'(1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check1("flush_no_stale", VW'(out_valid), VW'(1'b0));
    issue(VOP_ADD, 1'b1, 1'b0, splat(1), splat(2), 32'd0, splat(3), 1'b0);
    drain();

    // Reset mid-operation discards work and zeroes result
    out_ready = 1'b0;
    issue(VOP_ADD, 1'b1, 1'b0, splat(8), splat(8), 32'd0, splat(16), 1'b0);
    issue(VOP_ADD, 1'b1, 1'b0, splat(9), splat(8), 32'd0, splat(17), 1'b0);
    check1("pre_rst_result", result, splat(16));
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
    check1("mrst_out_valid", VW'(out_valid), VW'(1'b0));
    check1("mrst_result", result, '0);
    check1("mrst_zero", VW'(zero), VW'(1'b0));
    check1("mrst_in_ready", VW'(in_ready), VW'(1'b1));
    out_ready = 1'b1;
    issue(VOP_PASSB, 1'b0, 1'b1, splat(0), splat(0), 32'h55, mk(32'h55, 0, 0, 0, 0, 0), 1'b0);
    drain();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

endmodule
